execute_port3_issue_buffer: RTL and testbench
=============================================

Name: execute_port3_issue_buffer

Overview:
- In-order FIFO between the scheduler's ALU3 issue slot and the load/store execute port.
- Absorbs port backpressure so the scheduler can keep issuing load/store and SPR ops while a load waits for memory or the data port is busy.
- Presents the head entry first-word-fall-through on the port's previous-stage input bundle.
- Pops the head on every cycle the port is not locked.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- DEPTH_N, 2, log2(DEPTH); pointer width.

Ports:
- iCLOCK  input  1  clock; all logic on the rising edge.
- inRESET  input  1  reset; synchronous, active-low.
- iRESET_SYNC  input  1  synchronous flush, active-high.
- iFREE_EX  input  1  exception/branch-miss flush, active-high.
- iSCHE_VALID  input  1  scheduler issues one op this cycle.
- iSCHE_DESTINATION_SYSREG  input  1  op payload.
- iSCHE_COMMIT_TAG  input  6  op payload.
- iSCHE_CMD  input  5  op payload.
- iSCHE_SOURCE0  input  32  op payload.
- iSCHE_SOURCE1  input  32  op payload.
- iSCHE_ADV_ACTIVE  input  1  op payload.
- iSCHE_ADV_DATA  input  6  op payload.
- iSCHE_DESTINATION_REGNAME  input  6  op payload.
- iSCHE_PC  input  32  op payload.
- iSCHE_SYS_LDST  input  1  op payload.
- iSCHE_LDST  input  1  op payload.
- oSCHE_LOCK  output  1  buffer full; scheduler must not issue.
- oSCHE_COUNT  output  DEPTH_N+1  current occupancy.
- oNEXT_VALID  output  1  head entry valid.
- oNEXT_DESTINATION_SYSREG, oNEXT_COMMIT_TAG, oNEXT_CMD, oNEXT_SOURCE0, oNEXT_SOURCE1, oNEXT_ADV_ACTIVE, oNEXT_ADV_DATA, oNEXT_DESTINATION_REGNAME, oNEXT_PC, oNEXT_SYS_LDST, oNEXT_LDST  output  same widths as the iSCHE_ fields  head-entry payload.
- iNEXT_LOCK  input  1  execute port lock; head is held while high.

Behaviour:
- Storage: DEPTH x 123-bit entry array, write pointer wp, read pointer rp (each DEPTH_N bits, wrap modulo DEPTH), count (DEPTH_N+1 bits).
- Reset (inRESET low at a clock edge) sets wp=0, rp=0, count=0. Resulting outputs: oNEXT_VALID=0, oSCHE_LOCK=0, oSCHE_COUNT=0, all oNEXT payload outputs=0. Entry array contents are not reset.
- Flush: iRESET_SYNC or iFREE_EX high at an edge gives the same pointer and count result as reset. Flush wins over any push or pop in that cycle; the pushed op is dropped.
- push = iSCHE_VALID && !oSCHE_LOCK. A push writes the payload at wp; wp increments.
  - iSCHE_VALID while oSCHE_LOCK=1 is a scheduler protocol violation; the buffer ignores the op. The bench flags it with an assertion.
- pop = oNEXT_VALID && !iNEXT_LOCK. A pop increments rp.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- oNEXT_VALID = (count != 0), combinational from registers.
  - oNEXT payload = entry[rp] when valid; forced to 0 when empty.
  - Head payload is stable while iNEXT_LOCK is high.
- oSCHE_LOCK = (count == DEPTH), combinational from registers.
  - Asserted even when a pop occurs in the same cycle; there is no full-bypass.
- oSCHE_COUNT = count.
- Latency: an op pushed at edge N appears on oNEXT at edge N (registered entry), provided it was empty. There is no same-cycle bypass from iSCHE to oNEXT.
- Ordering: strictly in order; no entry reordering or payload modification.
- Simultaneous push and pop when count=1: head advances to the new entry, count stays 1.
- Simultaneous push and pop when empty is impossible, since pop requires valid.
- Wrap: wp and rp wrap from DEPTH-1 to 0 without a bubble.

Test Plan:
- Reset/flush: assert inRESET low for 2 cycles with iSCHE_VALID=1 -> oNEXT_VALID=0, oSCHE_COUNT=0, oSCHE_LOCK=0. After release, a push of tag 0x05 gives oNEXT_VALID=1 and oNEXT_COMMIT_TAG=0x05 the next cycle.
- Fill under lock: iNEXT_LOCK=1, push tags 1,2,3,4 -> oSCHE_COUNT=4, oSCHE_LOCK=1, head tag=1. A 5th iSCHE_VALID is ignored and the count stays 4.
- Drain order: from full, drop iNEXT_LOCK -> tags 1,2,3,4 pop on 4 consecutive cycles. oNEXT_VALID then falls and the payload reads 0.
- Streaming wrap: iNEXT_LOCK=0, push 10 ops on consecutive cycles with PC=0x100+4i -> output PCs appear in order one cycle after each push. oSCHE_COUNT never exceeds 1; pointers wrap twice.
- Flush priority: with count=3, assert iFREE_EX together with iSCHE_VALID (tag 0x2A) and a pop -> next cycle count=0, oNEXT_VALID=0, and tag 0x2A never appears.
- Lock-hold stability: head SOURCE0=0xDEADBEEF, iNEXT_LOCK high for 5 cycles while pushing 2 more ops -> oNEXT_SOURCE0 holds 0xDEADBEEF and oSCHE_COUNT goes 1, 2, 3.

Source files
------------

// File: rtl/execute_port3_issue_buffer.sv
// In-order first-word-fall-through issue buffer between the scheduler's ALU3 slot
// and the load/store execute port; absorbs port backpressure.
module execute_port3_issue_buffer #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic               iFREE_EX,
  input  logic               iSCHE_VALID,
  input  logic               iSCHE_DESTINATION_SYSREG,
  input  logic [5:0]         iSCHE_COMMIT_TAG,
  input  logic [4:0]         iSCHE_CMD,
  input  logic [31:0]        iSCHE_SOURCE0,
  input  logic [31:0]        iSCHE_SOURCE1,
  input  logic               iSCHE_ADV_ACTIVE,
  input  logic [5:0]         iSCHE_ADV_DATA,
  input  logic [5:0]         iSCHE_DESTINATION_REGNAME,
  input  logic [31:0]        iSCHE_PC,
  input  logic               iSCHE_SYS_LDST,
  input  logic               iSCHE_LDST,
  output logic               oSCHE_LOCK,
  output logic [DEPTH_N:0]   oSCHE_COUNT,
  output logic               oNEXT_VALID,
  output logic               oNEXT_DESTINATION_SYSREG,
  output logic [5:0]         oNEXT_COMMIT_TAG,
  output logic [4:0]         oNEXT_CMD,
  output logic [31:0]        oNEXT_SOURCE0,
  output logic [31:0]        oNEXT_SOURCE1,
  output logic               oNEXT_ADV_ACTIVE,
  output logic [5:0]         oNEXT_ADV_DATA,
  output logic [5:0]         oNEXT_DESTINATION_REGNAME,
  output logic [31:0]        oNEXT_PC,
  output logic               oNEXT_SYS_LDST,
  output logic               oNEXT_LDST,
  input  logic               iNEXT_LOCK
);

  typedef struct packed {
    logic        destination_sysreg;
    logic [5:0]  commit_tag;
    logic [4:0]  cmd;
    logic [31:0] source0;
    logic [31:0] source1;
    logic        adv_active;
    logic [5:0]  adv_data;
    logic [5:0]  destination_regname;
    logic [31:0] pc;
    logic        sys_ldst;
    logic        ldst;
  } entry_t;

  localparam logic [DEPTH_N:0]   FULL_COUNT = (DEPTH_N + 1)'(DEPTH);
  localparam logic [DEPTH_N:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_N-1:0] PTR_ONE    = 1;

  entry_t               mem [DEPTH];
  entry_t               sche_entry;
  entry_t               head;
  logic [DEPTH_N-1:0]   wp;
  logic [DEPTH_N-1:0]   rp;
  logic [DEPTH_N:0]     count;
  logic                 push;
  logic                 pop;
  logic                 flush;

  assign sche_entry = '{
    destination_sysreg:  iSCHE_DESTINATION_SYSREG,
    commit_tag:          iSCHE_COMMIT_TAG,
    cmd:                 iSCHE_CMD,
    source0:             iSCHE_SOURCE0,
    source1:             iSCHE_SOURCE1,
    adv_active:          iSCHE_ADV_ACTIVE,
    adv_data:            iSCHE_ADV_DATA,
    destination_regname: iSCHE_DESTINATION_REGNAME,
    pc:                  iSCHE_PC,
    sys_ldst:            iSCHE_SYS_LDST,
    ldst:                iSCHE_LDST
  };

  assign oNEXT_VALID = (count != '0);
  assign oSCHE_LOCK  = (count == FULL_COUNT);
  assign oSCHE_COUNT = count;

  // Full lock ignores a same-cycle pop on purpose: no bypass path from pop to push.
  assign push  = iSCHE_VALID && !oSCHE_LOCK;
  assign pop   = oNEXT_VALID && !iNEXT_LOCK;
  assign flush = iRESET_SYNC || iFREE_EX;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // NOTE: the entry array has no reset; count gates visibility, so stale data never escapes.
  always_ff @(posedge iCLOCK) begin
    if (push) mem[wp] <= sche_entry;
  end

  // NOTE: default first in always_comb so no path leaves head unassigned (no latch).
  always_comb begin
    head = '0;
    if (oNEXT_VALID) head = mem[rp];
  end

  assign oNEXT_DESTINATION_SYSREG  = head.destination_sysreg;
  assign oNEXT_COMMIT_TAG          = head.commit_tag;
  assign oNEXT_CMD                 = head.cmd;
  assign oNEXT_SOURCE0             = head.source0;
  assign oNEXT_SOURCE1             = head.source1;
  assign oNEXT_ADV_ACTIVE          = head.adv_active;
  assign oNEXT_ADV_DATA            = head.adv_data;
  assign oNEXT_DESTINATION_REGNAME = head.destination_regname;
  assign oNEXT_PC                  = head.pc;
  assign oNEXT_SYS_LDST            = head.sys_ldst;
  assign oNEXT_LDST                = head.ldst;

endmodule

// File: tb/tb_execute_port3_issue_buffer.sv
// Bench for execute_port3_issue_buffer: directed vector table, hand sequences for
// streaming/lock-hold, then random traffic against a queue reference model.
module tb_execute_port3_issue_buffer;

  localparam int DEPTH   = 4;
  localparam int DEPTH_N = 2;

  typedef struct packed {
    logic        dst_sysreg;
    logic [5:0]  tag;
    logic [4:0]  cmd;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        adv_active;
    logic [5:0]  adv_data;
    logic [5:0]  regname;
    logic [31:0] pc;
    logic        sys_ldst;
    logic        ldst;
  } op_t;

  typedef struct {
    logic       rst_n, sync, free, valid;
    logic [5:0] tag;
    logic       next_lock, allow;
    logic [2:0] e_cnt;
    logic       e_valid, e_lock;
    logic [5:0] e_tag;
  } vec_t;

  logic             clk = 0;
  logic             rst_n, sync_flush, free_ex, sche_valid, next_lock;
  logic             allow_violation = 0;
  op_t              in_op, out_op;
  logic             sche_lock, next_valid;
  logic [DEPTH_N:0] sche_count;
  int               n_cmp = 0, n_bad = 0, viol_cnt = 0;

  always #5 clk = ~clk;

  execute_port3_issue_buffer #(.DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync_flush), .iFREE_EX(free_ex),
    .iSCHE_VALID(sche_valid),
    .iSCHE_DESTINATION_SYSREG(in_op.dst_sysreg), .iSCHE_COMMIT_TAG(in_op.tag),
    .iSCHE_CMD(in_op.cmd), .iSCHE_SOURCE0(in_op.src0), .iSCHE_SOURCE1(in_op.src1),
    .iSCHE_ADV_ACTIVE(in_op.adv_active), .iSCHE_ADV_DATA(in_op.adv_data),
    .iSCHE_DESTINATION_REGNAME(in_op.regname), .iSCHE_PC(in_op.pc),
    .iSCHE_SYS_LDST(in_op.sys_ldst), .iSCHE_LDST(in_op.ldst),
    .oSCHE_LOCK(sche_lock), .oSCHE_COUNT(sche_count), .oNEXT_VALID(next_valid),
    .oNEXT_DESTINATION_SYSREG(out_op.dst_sysreg), .oNEXT_COMMIT_TAG(out_op.tag),
    .oNEXT_CMD(out_op.cmd), .oNEXT_SOURCE0(out_op.src0), .oNEXT_SOURCE1(out_op.src1),
    .oNEXT_ADV_ACTIVE(out_op.adv_active), .oNEXT_ADV_DATA(out_op.adv_data),
    .oNEXT_DESTINATION_REGNAME(out_op.regname), .oNEXT_PC(out_op.pc),
    .oNEXT_SYS_LDST(out_op.sys_ldst), .oNEXT_LDST(out_op.ldst),
    .iNEXT_LOCK(next_lock)
  );

  // Issuing into a full buffer is a scheduler bug; only the deliberate directed case is tolerated.
  always @(posedge clk) begin
    if (rst_n && sche_valid && sche_lock) begin
      if (allow_violation) viol_cnt <= viol_cnt + 1;
      else assert (0) else $error("scheduler issued while oSCHE_LOCK was high");
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t mk_op(input logic [5:0] tag);
    op_t o;
    o.dst_sysreg = tag[0];
    o.tag        = tag;
    o.cmd        = tag[4:0] ^ 5'h15;
    o.src0       = {tag, 26'h0} | 32'h1234;
    o.src1       = ~{26'h0, tag};
    o.adv_active = tag[1];
    o.adv_data   = ~tag;
    o.regname    = tag + 6'd1;
    o.pc         = 32'h1000 + 32'(tag) * 32'd4;
    o.sys_ldst   = tag[2];
    o.ldst       = tag[3];
    return o;
  endfunction

  function automatic vec_t mkv(input logic rst_n_i, sync_i, free_i, valid_i, input logic [5:0] tag_i,
                               input logic lock_i, allow_i, input logic [2:0] cnt_i,
                               input logic valid_o, lock_o, input logic [5:0] tag_o);
    vec_t v;
    v.rst_n = rst_n_i; v.sync = sync_i; v.free = free_i; v.valid = valid_i; v.tag = tag_i;
    v.next_lock = lock_i; v.allow = allow_i;
    v.e_cnt = cnt_i; v.e_valid = valid_o; v.e_lock = lock_o; v.e_tag = tag_o;
    return v;
  endfunction

  vec_t vecs[22];
  op_t  model_q[$];
  op_t  exp_head;

  initial begin
    rst_n = 0; sync_flush = 0; free_ex = 0; sche_valid = 0; next_lock = 0; in_op = '0;

    //            rst sync free vld tag    lock allow  cnt vld lock tag
    vecs[0]  = mkv(0, 0, 0, 1, 6'h09, 0, 0,  3'd0, 0, 0, 6'h00);
    vecs[1]  = mkv(0, 0, 0, 1, 6'h09, 0, 0,  3'd0, 0, 0, 6'h00);
    vecs[2]  = mkv(1, 0, 0, 1, 6'h05, 1, 0,  3'd1, 1, 0, 6'h05);
    vecs[3]  = mkv(1, 1, 0, 1, 6'h07, 1, 0,  3'd0, 0, 0, 6'h00);
    vecs[4]  = mkv(1, 0, 0, 1, 6'h01, 1, 0,  3'd1, 1, 0, 6'h01);
    vecs[5]  = mkv(1, 0, 0, 1, 6'h02, 1, 0,  3'd2, 1, 0, 6'h01);
    vecs[6]  = mkv(1, 0, 0, 1, 6'h03, 1, 0,  3'd3, 1, 0, 6'h01);
    vecs[7]  = mkv(1, 0, 0, 1, 6'h04, 1, 0,  3'd4, 1, 1, 6'h01);
    vecs[8]  = mkv(1, 0, 0, 1, 6'h06, 1, 1,  3'd4, 1, 1, 6'h01);
    vecs[9]  = mkv(1, 0, 0, 0, 6'h00, 0, 0,  3'd3, 1, 0, 6'h02);
    vecs[10] = mkv(1, 0, 0, 0, 6'h00, 0, 0,  3'd2, 1, 0, 6'h03);
    vecs[11] = mkv(1, 0, 0, 0, 6'h00, 0, 0,  3'd1, 1, 0, 6'h04);
    vecs[12] = mkv(1, 0, 0, 0, 6'h00, 0, 0,  3'd0, 0, 0, 6'h00);
    vecs[13] = mkv(1, 0, 0, 1, 6'h0B, 1, 0,  3'd1, 1, 0, 6'h0B);
    vecs[14] = mkv(1, 0, 0, 1, 6'h0C, 1, 0,  3'd2, 1, 0, 6'h0B);
    vecs[15] = mkv(1, 0, 0, 1, 6'h0D, 1, 0,  3'd3, 1, 0, 6'h0B);
    vecs[16] = mkv(1, 0, 1, 1, 6'h2A, 0, 0,  3'd0, 0, 0, 6'h00);
    vecs[17] = mkv(1, 0, 0, 0, 6'h00, 0, 0,  3'd0, 0, 0, 6'h00);
    vecs[18] = mkv(1, 0, 0, 1, 6'h14, 0, 0,  3'd1, 1, 0, 6'h14);
    vecs[19] = mkv(1, 0, 0, 1, 6'h15, 0, 0,  3'd1, 1, 0, 6'h15);
    vecs[20] = mkv(1, 0, 0, 0, 6'h00, 1, 0,  3'd1, 1, 0, 6'h15);
    vecs[21] = mkv(1, 0, 0, 0, 6'h00, 0, 0,  3'd0, 0, 0, 6'h00);

    for (int i = 0; i < 22; i++) begin
      rst_n = vecs[i].rst_n; sync_flush = vecs[i].sync; free_ex = vecs[i].free;
      sche_valid = vecs[i].valid; in_op = mk_op(vecs[i].tag);
      next_lock = vecs[i].next_lock; allow_violation = vecs[i].allow;
      tick();
      check($sformatf("vec%0d_status", i), 128'({next_valid, sche_lock, sche_count}),
            128'({vecs[i].e_valid, vecs[i].e_lock, vecs[i].e_cnt}));
      exp_head = vecs[i].e_valid ? mk_op(vecs[i].e_tag) : '0;
      check($sformatf("vec%0d_head", i), 128'(out_op), 128'(exp_head));
    end
    allow_violation = 0;
    check("violation_seen_once", 128'(viol_cnt), 128'(1));

    // Streaming with the port free: each op lands at the head one edge after its push.
    next_lock = 0;
    for (int i = 0; i < 10; i++) begin
      sche_valid = 1;
      in_op = mk_op(6'(50 + i));
      in_op.pc = 32'h100 + 32'(i) * 32'd4;
      exp_head = in_op;
      tick();
      check($sformatf("stream%0d_count", i), 128'(sche_count), 128'(1));
      check($sformatf("stream%0d_head", i), 128'(out_op), 128'(exp_head));
    end
    sche_valid = 0;
    tick();
    check("stream_drained", 128'({next_valid, sche_count}), 128'(0));

    // Lock held for five cycles: head payload must not move while entries pile up.
    next_lock = 1;
    for (int i = 0; i < 5; i++) begin
      sche_valid = (i < 3);
      in_op = mk_op(6'(40 + i));
      if (i == 0) in_op.src0 = 32'hDEADBEEF;
      tick();
      check($sformatf("hold%0d_src0", i), 128'(out_op.src0), 128'(32'hDEADBEEF));
      check($sformatf("hold%0d_count", i), 128'(sche_count), 128'((i < 3) ? i + 1 : 3));
    end
    sche_valid = 0; sync_flush = 1;
    tick();
    sync_flush = 0;
    check("hold_flushed", 128'({next_valid, sche_lock, sche_count}), 128'(0));

    // Random traffic against an in-order queue model.
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic [127:0] r;
      logic         do_flush, do_push, do_pop;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_op      = r[122:0];
      do_flush   = ($urandom_range(0, 39) == 0);
      sync_flush = do_flush && r[127];
      free_ex    = do_flush && !r[127];
      sche_valid = (model_q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      next_lock  = ($urandom_range(0, 9) < 4);
      if (do_flush) model_q.delete();
      else begin
        do_push = sche_valid && (model_q.size() < DEPTH);
        do_pop  = (model_q.size() > 0) && !next_lock;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(in_op);
      end
      tick();
      check($sformatf("rand%0d_status", c), 128'({next_valid, sche_lock, sche_count}),
            128'({model_q.size() != 0, model_q.size() == DEPTH, 3'(model_q.size())}));
      exp_head = (model_q.size() != 0) ? model_q[0] : '0;
      check($sformatf("rand%0d_head", c), 128'(out_op), 128'(exp_head));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
